// File: rtl/cpu_types_pkg.sv
// Shared types for the datapath/memory interface and the memory-side responder.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {IDLE, ACCESS} resp_state_t;

   typedef enum logic [1:0] {IREAD, DREAD, DWRITE} resp_kind_t;

   localparam word_t BADWORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/resp_ram.sv
// Single-clock word RAM: one async read port, two write ports (A over B on a shared index).
module resp_ram
   import cpu_types_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  word_t             a_data,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  word_t             b_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output word_t             rd_data
);

   word_t mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (a_we)
         mem[a_addr] <= a_data;
      if (b_we && !(a_we && a_addr == b_addr))
         mem[b_addr] <= b_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/datapath_mem_responder.sv
// Memory-side responder for datapath instruction/data requests with a fixed access latency.
module datapath_mem_responder
   import cpu_types_pkg::*;
#(
   parameter int    ADDR_W  = 10,
   parameter int    LATENCY = 2,
   parameter word_t BADWORD = BADWORD_DEFAULT
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              imemREN,
   input  word_t             imemaddr,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  word_t             dmemaddr,
   input  word_t             dmemstore,
   input  logic              ld_WEN,
   input  logic [ADDR_W-1:0] ld_addr,
   input  word_t             ld_data,
   output logic              ihit,
   output word_t             imemload,
   output logic              dhit,
   output word_t             dmemload
);

   resp_state_t       state;
   resp_kind_t        kind, next_kind;
   logic [ADDR_W-1:0] idx;
   logic              oor;
   logic [3:0]        cnt;
   word_t             req_addr, ram_word, rd_word;
   logic              any_req, req_live, hit_cycle;
   logic              unused_lsb;

   assign any_req  = imemREN | dmemREN | dmemWEN;
   assign req_addr = (dmemWEN | dmemREN) ? dmemaddr : imemaddr;
   assign unused_lsb = ^req_addr[1:0];

   always_comb begin
      next_kind = IREAD;
      if (dmemWEN)
         next_kind = DWRITE;
      else if (dmemREN)
         next_kind = DREAD;
   end

   // The strobe of the latched type must stay high; dropping it aborts the access.
   always_comb begin
      case (kind)
         DREAD:   req_live = dmemREN;
         DWRITE:  req_live = dmemWEN;
         default: req_live = imemREN;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         kind  <= IREAD;
         idx   <= '0;
         oor   <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               state <= ACCESS;
               kind  <= next_kind;
               idx   <= req_addr[ADDR_W+1:2];
               oor   <= |req_addr[31:ADDR_W+2];
               cnt   <= 4'(LATENCY);
            end
            default: begin
               if (!req_live || cnt == 4'd0)
                  state <= IDLE;
               else
                  cnt <= cnt - 4'd1;
            end
         endcase
      end
   end

   assign hit_cycle = (state == ACCESS) && (cnt == 4'd0) && req_live;
   assign ihit      = hit_cycle && (kind == IREAD);
   assign dhit      = hit_cycle && (kind != IREAD);
   assign rd_word   = oor ? BADWORD : ram_word;
   assign imemload  = ihit ? rd_word : '0;
   assign dmemload  = (hit_cycle && kind == DREAD) ? rd_word : '0;

   resp_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk     (CLK),
      .a_we    (ld_WEN),
      .a_addr  (ld_addr),
      .a_data  (ld_data),
      .b_we    (hit_cycle && kind == DWRITE && !oor),
      .b_addr  (idx),
      .b_data  (dmemstore),
      .rd_addr (idx),
      .rd_data (ram_word)
   );

endmodule

// File: tb/tb_datapath_mem_responder.sv
// Directed bench for datapath_mem_responder: LATENCY=2 main instance plus a LATENCY=0 instance.
module tb_datapath_mem_responder;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0, RST = 1'b1;
   logic        imemREN = 0, dmemREN = 0, dmemWEN = 0, ld_WEN = 0;
   word_t       imemaddr = '0, dmemaddr = '0, dmemstore = '0, ld_data = '0;
   logic [9:0]  ld_addr = '0;
   logic        ihit, dhit;
   word_t       imemload, dmemload;

   logic        imemREN0 = 0;
   word_t       imemaddr0 = '0;
   logic        ihit0, dhit0;
   word_t       imemload0, dmemload0;

   int checks = 0, errors = 0;
   int n;

   always #5 CLK = ~CLK;

   datapath_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
      .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .ld_WEN(ld_WEN), .ld_addr(ld_addr), .ld_data(ld_data),
      .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload)
   );

   datapath_mem_responder #(.ADDR_W(10), .LATENCY(0)) dut0 (
      .CLK(CLK), .RST(RST), .imemREN(imemREN0), .imemaddr(imemaddr0),
      .dmemREN(1'b0), .dmemWEN(1'b0), .dmemaddr(32'h0), .dmemstore(32'h0),
      .ld_WEN(ld_WEN), .ld_addr(ld_addr), .ld_data(ld_data),
      .ihit(ihit0), .imemload(imemload0), .dhit(dhit0), .dmemload(dmemload0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic preload(input int i, input word_t d);
      ld_WEN  = 1'b1;
      ld_addr = 10'(i);
      ld_data = d;
      tick();
      ld_WEN  = 1'b0;
   endtask

   // Edges until a hit is seen, bounded; result is the cycle index after acceptance.
   task automatic wait_hit(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!(ihit || dhit) && cyc < 20);
      chk("hit_seen", 32'(ihit | dhit), 32'd1);
      chk("no_overlap", 32'(ihit & dhit), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      #12;
      chk("rst_ihit", 32'(ihit), 0);
      chk("rst_dhit", 32'(dhit), 0);
      chk("rst_imemload", imemload, 0);
      chk("rst_dmemload", dmemload, 0);
      chk("rst_ihit0", 32'(ihit0), 0);
      tick();
      RST = 1'b0;

      preload(0, 32'h11111111);
      preload(1, 32'h22222222);
      preload(2, 32'h33333333);
      preload(3, 32'h2001000A);
      preload(16, 32'h0);
      preload(17, 32'h17171717);

      // 1: instruction read, hit exactly in cycle 3
      imemREN = 1'b1; imemaddr = 32'hC;
      tick();
      chk("t1_c1_ihit", 32'(ihit), 0);
      chk("t1_c1_load", imemload, 0);
      tick();
      chk("t1_c2_ihit", 32'(ihit), 0);
      chk("t1_c2_load", imemload, 0);
      tick();
      chk("t1_c3_ihit", 32'(ihit), 1);
      chk("t1_c3_load", imemload, 32'h2001000A);
      chk("t1_c3_dhit", 32'(dhit), 0);
      tick();
      imemREN = 1'b0;
      chk("t1_after_ihit", 32'(ihit), 0);
      chk("t1_after_load", imemload, 0);

      // 2: write then read back
      dmemWEN = 1'b1; dmemaddr = 32'h40; dmemstore = 32'hCAFEF00D;
      wait_hit(n);
      chk("t2_wr_lat", 32'(n), 3);
      chk("t2_wr_dhit", 32'(dhit), 1);
      chk("t2_wr_load", dmemload, 0);
      tick();
      dmemWEN = 1'b0;
      dmemREN = 1'b1;
      wait_hit(n);
      chk("t2_rd_dhit", 32'(dhit), 1);
      chk("t2_rd_load", dmemload, 32'hCAFEF00D);
      tick();
      dmemREN = 1'b0;

      // 3: simultaneous requests, data first
      imemREN = 1'b1; imemaddr = 32'hC; dmemREN = 1'b1; dmemaddr = 32'h40;
      wait_hit(n);
      chk("t3_dhit", 32'(dhit), 1);
      chk("t3_ihit_low", 32'(ihit), 0);
      chk("t3_dload", dmemload, 32'hCAFEF00D);
      tick();
      dmemREN = 1'b0;
      wait_hit(n);
      chk("t3_gap", 32'(n + 1), 4);
      chk("t3_ihit", 32'(ihit), 1);
      chk("t3_iload", imemload, 32'h2001000A);
      chk("t3_dload0", dmemload, 0);
      tick();
      imemREN = 1'b0;

      // 4: out of range read and write
      dmemREN = 1'b1; dmemaddr = 32'h0010_0000;
      wait_hit(n);
      chk("t4_rd_load", dmemload, 32'hBAD1BAD1);
      tick();
      dmemREN = 1'b0;
      dmemWEN = 1'b1; dmemstore = 32'hDEADBEEF;
      wait_hit(n);
      chk("t4_wr_dhit", 32'(dhit), 1);
      tick();
      dmemWEN = 1'b0;
      dmemREN = 1'b1; dmemaddr = 32'h0;
      wait_hit(n);
      chk("t4_ram_intact", dmemload, 32'h11111111);
      tick();
      dmemREN = 1'b0;

      // 5a: abort a write mid-access
      dmemWEN = 1'b1; dmemaddr = 32'h44; dmemstore = 32'h55555555;
      tick();
      tick();
      dmemWEN = 1'b0;
      chk("t5_abort_now", 32'(dhit), 0);
      tick();
      chk("t5_abort_c3", 32'(dhit), 0);
      tick();
      chk("t5_abort_c4", 32'(dhit), 0);
      dmemREN = 1'b1;
      wait_hit(n);
      chk("t5_abort_ram", dmemload, 32'h17171717);
      tick();
      dmemREN = 1'b0;

      // 5b: reset during the hit cycle
      imemREN = 1'b1; imemaddr = 32'hC;
      tick(); tick(); tick();
      chk("t5_pre_rst_ihit", 32'(ihit), 1);
      RST = 1'b1;
      #1;
      chk("t5_rst_ihit", 32'(ihit), 0);
      chk("t5_rst_iload", imemload, 0);
      imemREN = 1'b0;
      tick();
      RST = 1'b0;
      imemREN = 1'b1;
      wait_hit(n);
      chk("t5_post_lat", 32'(n), 3);
      chk("t5_post_load", imemload, 32'h2001000A);
      tick();
      imemREN = 1'b0;

      // 6: LATENCY=0, back-to-back fetches hit every second cycle
      imemREN0 = 1'b1; imemaddr0 = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_ihit", 32'(ihit0), 1);
         chk("t6_load", imemload0, (i == 0) ? 32'h11111111 : (i == 1) ? 32'h22222222 : 32'h33333333);
         imemaddr0 = 32'((i + 1) * 4);
         tick();
         chk("t6_gap_ihit", 32'(ihit0), 0);
         chk("t6_gap_load", imemload0, 0);
      end
      imemREN0 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
